ex_mem_stage_v4: RTL and testbench
==================================

Name: ex_mem_stage_v4

Overview:
- Parametrised EX->MEM pipeline stage register, successor to the fixed-width EX/MEM latch.
- Adds a valid/ready handshake and a 2-entry skid buffer, so a MEM-side stall does not combinationally stall EX.
- Adds synchronous flush and NOP/bubble filtering: inactive instructions are consumed but never enqueued, so no payload register toggles.
- Adds a saturating dropped-bubble counter for power/perf profiling.

Parameters:
- XLEN, 32, width of rs2 / result / branch_address fields
- RD_W, 5, destination register index width
- MEMC_W, 2, MEM control field width
- WBC_W, 2, WB control field width
- CNT_W, 16, width of the dropped-bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous kill of all held entries (branch taken / trap)
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rd  in  RD_W  destination register
- in_mem_control  in  MEMC_W  MEM control
- in_wb_control  in  WBC_W  WB control
- in_branch  in  1  branch flag
- in_rs2  in  XLEN  store data
- in_result  in  XLEN  ALU result
- in_branch_address  in  XLEN  branch target
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes this cycle
- out_rd  out  RD_W  mirrors in_rd
- out_mem_control  out  MEMC_W  mirrors in_mem_control
- out_wb_control  out  WBC_W  mirrors in_wb_control
- out_branch  out  1  mirrors in_branch
- out_write_data  out  XLEN  mirrors in_rs2
- out_result  out  XLEN  mirrors in_result
- out_branch_address  out  XLEN  mirrors in_branch_address
- bubble_count  out  CNT_W  saturating count of dropped NOPs

Behaviour:
- Reset (reset=0, async):
  - state=EMPTY.
  - All out_* payload, main and skid registers = 0.
  - out_valid=0, bubble_count=0.
  - in_ready=1 after release.
- active = in_valid & (|in_mem_control | |in_wb_control | in_branch).
- accept = in_valid & in_ready.
- enq = accept & active.
- deq = out_valid & out_ready.
- in_ready is a direct register decode: in_ready = (state != FULL). It is not combinationally dependent on out_ready.
- FSM states and actions:
  - EMPTY:
    - enq: load main; -> ONE.
  - ONE (main valid):
    - enq & deq: load main; stay ONE.
    - enq & !deq: load skid; -> FULL.
    - !enq & deq: -> EMPTY.
  - FULL (main+skid valid, in_ready=0):
    - deq: main<=skid; -> ONE.
    - otherwise hold.
- Latency: an accepted active instruction appears on out_* the cycle after acceptance. Throughput is 1/cycle while out_ready=1.
- Ordering is strictly FIFO. The skid entry never overtakes main.
- Bubble filtering:
  - accept & !active: the instruction is acknowledged but not stored.
  - No main or skid payload bit may change.
  - bubble_count increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- out_valid = (state != EMPTY).
- When out_valid=0:
  - out_mem_control, out_wb_control and out_branch are forced to 0.
  - out_rd and the XLEN data outputs hold their last values (no toggling).
- Flush (synchronous, highest priority):
  - Next state = EMPTY; a concurrent input is dropped and not counted.
  - Payload registers are not cleared.
  - bubble_count is unaffected.
  - in_ready during the flush cycle follows the current state.
- Simultaneous flush with deq: MEM still sees the current entry for that cycle; it is discarded at the edge.
- reset asserted mid-transfer: all state is lost immediately, asynchronously. No partial entry may survive.
- Widths are fixed by parameters. No truncation or extension happens inside the block.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, out_result=0, bubble_count=0; in_ready=1 on the first cycle after release.
- Streaming: out_ready=1; inject results 0x11, 0x22, 0x33 (wb_control=2'b01) on consecutive cycles -> same values on out_result one cycle later, in order, no gaps.
- Skid fill: ONE holding 0xA; set out_ready=0 and inject 0xB -> state FULL, in_ready=0, out_result=0xA. Raise out_ready -> 0xA, then 0xB; in_ready=1 the cycle after the first deq.
- Bubble drop: inject 4 all-zero-control instructions while holding 0x55 -> out_result stays 0x55, bubble_count=4, no payload toggles. With CNT_W=2, 5 bubbles -> bubble_count=3.
- Flush: state FULL (0xC, 0xD), assert flush with in_valid=1 and value 0xE -> next cycle out_valid=0 and out_mem_control=0; 0xE is never output.
- Async reset mid-stream: drop reset between edges while FULL -> outputs zero immediately; resume streaming 0x77 after release -> 0x77 is output correctly.

Source files
------------

// File: rtl/ex_mem_stage_v4.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_v4
//   EX->MEM pipeline stage register with a valid/ready handshake. A two-entry
//   skid buffer (main + skid) lets EX keep issuing for one cycle after MEM
//   stalls, so in_ready is a pure register decode and never depends
//   combinationally on out_ready. Inactive instructions (NOPs/bubbles) are
//   acknowledged but never stored, and a saturating counter tracks how many
//   were dropped. flush synchronously empties the stage.
//
// Ports
//   clk, reset            rising-edge clock, async active-low reset
//   flush                 synchronous kill of all held entries
//   in_valid / in_ready   EX-side handshake
//   in_*                  EX payload (rd, MEM/WB control, branch, rs2,
//                         result, branch target)
//   out_valid / out_ready MEM-side handshake
//   out_*                 MEM payload; control fields read 0 when invalid
//   bubble_count          saturating count of dropped NOPs
// ---------------------------------------------------------------------------
module ex_mem_stage_v4 #(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int MEMC_W = 2,
    parameter int WBC_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [MEMC_W-1:0] in_mem_control,
    input  logic [WBC_W-1:0]  in_wb_control,
    input  logic              in_branch,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_branch_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [MEMC_W-1:0] out_mem_control,
    output logic [WBC_W-1:0]  out_wb_control,
    output logic              out_branch,
    output logic [XLEN-1:0]   out_write_data,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_branch_address,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;  // main valid
    localparam logic [1:0] ST_FULL  = 2'd2;  // main + skid valid

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [MEMC_W-1:0] mem_control;
        logic [WBC_W-1:0]  wb_control;
        logic              branch;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   branch_address;
    } payload_t;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    payload_t         r_main;
    payload_t         r_skid;
    payload_t         w_in_payload;
    logic [CNT_W-1:0] r_bubble_count;

    logic w_active;
    logic w_accept;
    logic w_enq;
    logic w_deq;
    logic w_bubble;
    logic w_load_main_in;
    logic w_load_skid_in;
    logic w_load_main_skid;

    assign w_in_payload = {in_rd, in_mem_control, in_wb_control, in_branch,
                           in_rs2, in_result, in_branch_address};

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);

    assign w_active = in_valid & ((|in_mem_control) | (|in_wb_control) | in_branch);
    assign w_accept = in_valid & in_ready;
    assign w_enq    = w_accept & w_active;
    assign w_deq    = out_valid & out_ready;
    // A flushed input is dropped outright, so it is not counted as a bubble.
    assign w_bubble = w_accept & ~w_active & ~flush;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_skid_in   = 1'b0;
        w_load_main_skid = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_enq) begin
                        w_load_main_in = 1'b1;
                        w_next_state   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_enq && w_deq) begin
                        w_load_main_in = 1'b1;
                    end else if (w_enq) begin
                        w_load_skid_in = 1'b1;
                        w_next_state   = ST_FULL;
                    end else if (w_deq) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid->main shift can occur.
                    if (w_deq) begin
                        w_load_main_skid = 1'b1;
                        w_next_state     = ST_ONE;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_EMPTY;
            r_bubble_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_bubble && (r_bubble_count != {CNT_W{1'b1}})) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    // NOTE: the payload registers are plain flops, not a RAM, and they drive
    // the outputs directly, so they take the reset to read 0 while in reset.
    // They load only on an enqueue or skid shift, so bubbles never toggle them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_payload;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= w_in_payload;
            end
        end
    end

    // Control fields are gated off when nothing is valid; data fields hold so
    // that the wide buses do not toggle while the stage is idle.
    assign out_rd             = r_main.rd;
    assign out_mem_control    = out_valid ? r_main.mem_control : '0;
    assign out_wb_control     = out_valid ? r_main.wb_control  : '0;
    assign out_branch         = out_valid & r_main.branch;
    assign out_write_data     = r_main.rs2;
    assign out_result         = r_main.result;
    assign out_branch_address = r_main.branch_address;
    assign bubble_count       = r_bubble_count;

endmodule

// File: tb/tb_ex_mem_stage_v4.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_v4
//   Self-checking bench for ex_mem_stage_v4. A queue-based reference model
//   (capacity-2 FIFO, last-shown entry, saturating counters) predicts every
//   output; directed scenarios add constant expectations on top. A second
//   instance with CNT_W=2 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_v4;

    localparam int XLEN   = 32;
    localparam int RD_W   = 5;
    localparam int MEMC_W = 2;
    localparam int WBC_W  = 2;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [MEMC_W-1:0] mc;
        logic [WBC_W-1:0]  wc;
        logic              br;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   res;
        logic [XLEN-1:0]   ba;
    } ent_t;

    typedef struct packed {
        logic             valid;
        logic             ready;
        ent_t             e;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [RD_W-1:0]   in_rd = '0;
    logic [MEMC_W-1:0] in_mem_control = '0;
    logic [WBC_W-1:0]  in_wb_control = '0;
    logic              in_branch = 1'b0;
    logic [XLEN-1:0]   in_rs2 = '0;
    logic [XLEN-1:0]   in_result = '0;
    logic [XLEN-1:0]   in_branch_address = '0;

    logic              in_ready, out_valid, out_branch;
    logic [RD_W-1:0]   out_rd;
    logic [MEMC_W-1:0] out_mem_control;
    logic [WBC_W-1:0]  out_wb_control;
    logic [XLEN-1:0]   out_write_data, out_result, out_branch_address;
    logic [CNT_W-1:0]  bubble_count;

    logic              in_ready2, out_valid2, out_branch2;
    logic [RD_W-1:0]   out_rd2;
    logic [MEMC_W-1:0] out_mem_control2;
    logic [WBC_W-1:0]  out_wb_control2;
    logic [XLEN-1:0]   out_write_data2, out_result2, out_branch_address2;
    logic [1:0]        bubble_count2;

    always #5 clk = ~clk;

    ex_mem_stage_v4 #(.XLEN(XLEN), .RD_W(RD_W), .MEMC_W(MEMC_W), .WBC_W(WBC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_mem_control(in_mem_control), .in_wb_control(in_wb_control),
        .in_branch(in_branch), .in_rs2(in_rs2), .in_result(in_result),
        .in_branch_address(in_branch_address),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_mem_control(out_mem_control), .out_wb_control(out_wb_control),
        .out_branch(out_branch), .out_write_data(out_write_data), .out_result(out_result),
        .out_branch_address(out_branch_address), .bubble_count(bubble_count)
    );

    ex_mem_stage_v4 #(.XLEN(XLEN), .RD_W(RD_W), .MEMC_W(MEMC_W), .WBC_W(WBC_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_rd(in_rd), .in_mem_control(in_mem_control), .in_wb_control(in_wb_control),
        .in_branch(in_branch), .in_rs2(in_rs2), .in_result(in_result),
        .in_branch_address(in_branch_address),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_rd(out_rd2), .out_mem_control(out_mem_control2), .out_wb_control(out_wb_control2),
        .out_branch(out_branch2), .out_write_data(out_write_data2), .out_result(out_result2),
        .out_branch_address(out_branch_address2), .bubble_count(bubble_count2)
    );

    obs_t dut_obs;
    assign dut_obs = {out_valid, in_ready, out_rd, out_mem_control, out_wb_control, out_branch,
                      out_write_data, out_result, out_branch_address, bubble_count};

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- reference model ----------------
    ent_t        q[$];
    ent_t        last_front = '0;
    int unsigned cnt  = 0;
    int unsigned cnt2 = 0;

    task automatic model_reset();
        q.delete();
        last_front = '0;
        cnt  = 0;
        cnt2 = 0;
    endtask

    function automatic ent_t cur_in();
        return {in_rd, in_mem_control, in_wb_control, in_branch, in_rs2, in_result, in_branch_address};
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.valid = (q.size() != 0);
        o.ready = (q.size() < 2);
        o.e     = o.valid ? q[0] : last_front;
        if (!o.valid) begin
            o.e.mc = '0;
            o.e.wc = '0;
            o.e.br = 1'b0;
        end
        o.cnt = cnt[CNT_W-1:0];
        return o;
    endfunction

    // Called right after a rising edge while inputs still hold their values.
    task automatic model_update();
        ent_t inp;
        bit   act, rdy, dq;
        if (!reset) begin
            model_reset();
            return;
        end
        inp = cur_in();
        act = in_valid && (inp.mc != 0 || inp.wc != 0 || inp.br);
        rdy = (q.size() < 2);
        dq  = (q.size() != 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (dq) void'(q.pop_front());
            if (in_valid && rdy) begin
                if (act) q.push_back(inp);
                else begin
                    if (cnt < 65535) cnt++;
                    if (cnt2 < 3) cnt2++;
                end
            end
        end
        if (q.size() != 0) last_front = q[0];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input ent_t e);
        in_valid = v;
        {in_rd, in_mem_control, in_wb_control, in_branch, in_rs2, in_result, in_branch_address} = e;
    endtask

    function automatic ent_t mk(input logic [31:0] res, input logic [1:0] mc, input logic [1:0] wc);
        ent_t e;
        e.rd  = res[4:0];
        e.mc  = mc;
        e.wc  = wc;
        e.br  = 1'b0;
        e.rs2 = res ^ 32'hA5A5_0000;
        e.res = res;
        e.ba  = res + 32'h100;
        return e;
    endfunction

    function automatic ent_t rnd_ent(input bit allow_bubble);
        ent_t e;
        e.rd  = RD_W'($urandom);
        e.mc  = MEMC_W'($urandom);
        e.wc  = WBC_W'($urandom);
        e.br  = 1'($urandom);
        e.rs2 = $urandom;
        e.res = $urandom;
        e.ba  = $urandom;
        if (allow_bubble && $urandom_range(0, 9) < 3) begin
            e.mc = '0;
            e.wc = '0;
            e.br = 1'b0;
        end
        return e;
    endfunction

    task automatic pulse_reset();
        reset = 1'b0;
        drive(1'b0, '0);
        flush = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, mk(32'h99, 2'b01, 2'b01));
        out_ready = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_chk++;
            if (out_valid !== 1'b0 || out_result !== '0 || bubble_count !== '0)
                $display("FAIL reset[%0d]: valid=%b result=%h count=%0d, required 0/0/0",
                         i, out_valid, out_result, bubble_count);
            else n_pass++;
            n_chk++;
            if (dut_obs !== model_out())
                $display("FAIL reset_model[%0d]: got %h required %h", i, dut_obs, model_out());
            else n_pass++;
        end
        drive(1'b0, '0);
        reset = 1'b1;
        cycle();
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(vals[i], 2'b00, 2'b01));
            cycle();
            n_chk++;
            if (out_valid !== 1'b1 || out_result !== vals[i] || out_wb_control !== 2'b01)
                $display("FAIL stream[%0d]: valid=%b result=%h wb=%b, required 1/%h/01",
                         i, out_valid, out_result, out_wb_control, vals[i]);
            else n_pass++;
            n_chk++;
            if (dut_obs !== model_out())
                $display("FAIL stream_model[%0d]: got %h required %h", i, dut_obs, model_out());
            else n_pass++;
        end
        drive(1'b0, '0);
        cycle();
        n_chk++;
        if (out_valid !== 1'b0 || out_result !== 32'h33 || dut_obs !== model_out())
            $display("FAIL stream_drain: valid=%b result=%h, required 0/33", out_valid, out_result);
        else n_pass++;
    endtask

    task automatic test_skid();
        out_ready = 1'b1;
        drive(1'b1, mk(32'hA, 2'b01, 2'b00));
        cycle();
        out_ready = 1'b0;
        drive(1'b1, mk(32'hB, 2'b01, 2'b00));
        cycle();
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hA)
            $display("FAIL skid_full: in_ready=%b valid=%b result=%h, required 0/1/a",
                     in_ready, out_valid, out_result);
        else n_pass++;
        drive(1'b0, '0);
        out_ready = 1'b1;
        cycle();
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 32'hB || dut_obs !== model_out())
            $display("FAIL skid_drain: in_ready=%b valid=%b result=%h, required 1/1/b",
                     in_ready, out_valid, out_result);
        else n_pass++;
        cycle();
        n_chk++;
        if (out_valid !== 1'b0 || dut_obs !== model_out())
            $display("FAIL skid_empty: got %h required %h", dut_obs, model_out());
        else n_pass++;
    endtask

    task automatic test_bubble();
        ent_t b;
        pulse_reset();
        out_ready = 1'b0;
        drive(1'b1, mk(32'h55, 2'b10, 2'b01));
        cycle();
        for (int i = 0; i < 6; i++) begin
            b = rnd_ent(1'b0);
            b.mc = '0;
            b.wc = '0;
            b.br = 1'b0;
            drive(1'b1, b);
            cycle();
            n_chk++;
            if (out_result !== 32'h55 || out_write_data !== (32'h55 ^ 32'hA5A5_0000) ||
                out_valid !== 1'b1 || dut_obs !== model_out())
                $display("FAIL bubble_hold[%0d]: got %h required %h", i, dut_obs, model_out());
            else n_pass++;
            if (i == 3) begin
                n_chk++;
                if (bubble_count !== 16'd4)
                    $display("FAIL bubble_count4: got %0d required 4", bubble_count);
                else n_pass++;
            end
            n_chk++;
            if (bubble_count2 !== cnt2[1:0] || (i >= 4 && bubble_count2 !== 2'd3))
                $display("FAIL bubble_sat[%0d]: got %0d required %0d", i, bubble_count2, cnt2);
            else n_pass++;
        end
        drive(1'b0, '0);
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, mk(32'hC, 2'b10, 2'b00));
        cycle();
        drive(1'b1, mk(32'hD, 2'b10, 2'b00));
        cycle();
        flush = 1'b1;
        drive(1'b1, mk(32'hE, 2'b11, 2'b11));
        #1;
        n_chk++;
        if (in_ready !== 1'b0)
            $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        #0;
        cycle();
        flush = 1'b0;
        drive(1'b0, '0);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_mem_control !== '0 || dut_obs !== model_out())
            $display("FAIL flush_empty: valid=%b mem_ctl=%b, required 0/00", out_valid, out_mem_control);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cycle();
            n_chk++;
            if (out_valid !== 1'b0 || out_result === 32'hE || dut_obs !== model_out())
                $display("FAIL flush_nodata[%0d]: valid=%b result=%h, required 0 and not e",
                         i, out_valid, out_result);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, mk(32'h61, 2'b01, 2'b01));
        cycle();
        drive(1'b1, mk(32'h62, 2'b01, 2'b01));
        cycle();
        drive(1'b0, '0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_result !== '0 || in_ready !== 1'b1 ||
            bubble_count !== '0 || dut_obs !== model_out())
            $display("FAIL async_reset: got %h required %h", dut_obs, model_out());
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, mk(32'h77, 2'b00, 2'b10));
        cycle();
        drive(1'b0, '0);
        n_chk++;
        if (out_valid !== 1'b1 || out_result !== 32'h77 || dut_obs !== model_out())
            $display("FAIL async_resume: valid=%b result=%h, required 1/77", out_valid, out_result);
        else n_pass++;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_ent(1'b1));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
            n_chk++;
            if (dut_obs !== model_out() || bubble_count2 !== cnt2[1:0])
                $display("FAIL random[%0d]: got %h cnt2=%0d required %h cnt2=%0d",
                         i, dut_obs, bubble_count2, model_out(), cnt2);
            else n_pass++;
        end
        flush = 1'b0;
        drive(1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
